// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter and the pipeline
// control/mem stages that drive it.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // No-op load/store codes used by control and mem to mark "no memory access".
  localparam logic [2:0] LNONE = 3'd0;
  localparam logic [1:0] SNONE = 2'd0;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data with a saturating starvation streak:
// data wins by default until fetch has waited through STARVE_LIMIT data grants.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic i_req,
  input  logic d_req,
  input  logic grant,
  output logic sel_d
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] streak;
  logic          starved;

  assign starved = (streak == SW'(STARVE_LIMIT)) && i_req;
  assign sel_d   = d_req && !starved;

  // Streak only moves while the arbiter is deciding; WAIT cycles hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (idle) begin
      if (!i_req)
        streak <= '0;
      else if (grant) begin
        if (!sel_d)
          streak <= '0;
        else if (streak != SW'(STARVE_LIMIT))
          streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (read-only)
// and the mem stage, with starvation guard and response timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic [29:0] m_addr,
  output logic        m_re,
  output logic [3:0]  m_we,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state, state_nx;
  owner_e        owner;
  logic [TW-1:0] tmo_cnt;
  logic          idle, waiting, any_req, grant, sel_d;
  logic          tmo_hit, rsp_ok, rsp_err, own_i, own_d;

  // Qualifying with rst_n keeps every output at 0 while reset is held.
  assign idle    = rst_n && (state == IDLE);
  assign waiting = rst_n && (state == WAIT);
  assign any_req = i_req || d_req;
  assign grant   = idle && m_gnt && any_req;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign rsp_ok  = waiting && m_rvalid;
  assign rsp_err = waiting && !m_rvalid && tmo_hit;
  assign own_i   = (owner == OWN_I);
  assign own_d   = (owner == OWN_D);

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .idle  (idle),
    .i_req (i_req),
    .d_req (d_req),
    .grant (grant),
    .sel_d (sel_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= OWN_I;
      tmo_cnt <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner   <= sel_d ? OWN_D : OWN_I;
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (grant) state_nx = WAIT;
      WAIT: if (m_rvalid || tmo_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_req   = idle && any_req;
    m_addr  = '0;
    m_re    = 1'b0;
    m_we    = '0;
    m_wdata = '0;
    if (idle) begin
      if (sel_d) begin
        m_addr  = d_addr;
        m_re    = d_re;
        m_we    = d_we;
        m_wdata = d_wdata;
      end else begin
        m_addr = i_addr;
        m_re   = i_req;
      end
    end
  end

  assign i_gnt    = grant && !sel_d;
  assign d_gnt    = grant && sel_d;
  assign i_rvalid = (rsp_ok || rsp_err) && own_i;
  assign d_rvalid = (rsp_ok || rsp_err) && own_d;
  assign i_err    = rsp_err && own_i;
  assign d_err    = rsp_err && own_d;
  assign i_rdata  = (rsp_ok && own_i) ? m_rdata : 32'h0;
  assign d_rdata  = (rsp_ok && own_d) ? m_rdata : 32'h0;
  assign busy     = waiting;

  // A data request must carry a read or at least one byte-lane write.
  assert property (@(posedge clk) disable iff (!rst_n) d_req |-> (d_re || (d_we != 4'b0000)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: per-cycle table plus hand sequences
// for starvation order, timeout, and reset in the middle of a transaction.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [29:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_re, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        m_req, m_re, m_gnt, m_rvalid, busy;
  logic [29:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] m_wdata, m_rdata;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [7:0] F_IG = 8'h80, F_IV = 8'h40, F_IE = 8'h20, F_DG = 8'h10;
  localparam logic [7:0] F_DV = 8'h08, F_DE = 8'h04, F_MR = 8'h02, F_BS = 8'h01;

  logic [7:0] flg;
  assign flg = {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, busy};

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  typedef struct {
    logic        ir;
    logic [29:0] ia;
    logic        dr, dre;
    logic [3:0]  dwe;
    logic [29:0] da;
    logic [31:0] dwd;
    logic        mg, mv;
    logic [31:0] mrd;
    logic [7:0]  fl;
    logic [31:0] ird, drd;
    logic [29:0] ma;
    logic [3:0]  mwe;
    logic [31:0] mwd;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic ir, logic [29:0] ia, logic dr, logic dre, logic [3:0] dwe,
                              logic [29:0] da, logic [31:0] dwd, logic mg, logic mv,
                              logic [31:0] mrd, logic [7:0] fl, logic [31:0] ird,
                              logic [31:0] drd, logic [29:0] ma, logic [3:0] mwe,
                              logic [31:0] mwd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dre = dre; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.mg = mg; v.mv = mv; v.mrd = mrd; v.fl = fl; v.ird = ird; v.drd = drd;
    v.ma = ma; v.mwe = mwe; v.mwd = mwd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
  endtask

  string order_exp;
  int    ng;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    i_req = 1; d_req = 1; d_re = 1;
    #1;
    chk("reset_flags", {24'h0, flg}, 32'h0);
    chk("reset_m_addr", {2'b0, m_addr}, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // fetch only; write+fetch collision; m_gnt stall for 5 cycles
    tbl[0]  = mk(1,'h10, 0,0,4'h0,0,0,         1,0,32'h0,        F_IG|F_MR, 0,0, 'h10,4'h0,0);
    tbl[1]  = mk(0,0,    0,0,4'h0,0,0,         0,0,32'h0,        F_BS,      0,0, 0,0,0);
    tbl[2]  = mk(0,0,    0,0,4'h0,0,0,         0,0,32'h0,        F_BS,      0,0, 0,0,0);
    tbl[3]  = mk(0,0,    0,0,4'h0,0,0,         0,1,32'hDEADBEEF, F_IV|F_BS, 32'hDEADBEEF,0, 0,0,0);
    tbl[4]  = mk(0,0,    0,0,4'h0,0,0,         0,0,32'h0,        8'h00,     0,0, 0,0,0);
    tbl[5]  = mk(1,'h20, 1,0,4'b0011,'h40,'h1234, 1,0,32'h0,     F_DG|F_MR, 0,0, 'h40,4'b0011,'h1234);
    tbl[6]  = mk(1,'h20, 0,0,4'h0,0,0,         0,1,32'h0,        F_DV|F_BS, 0,0, 0,0,0);
    tbl[7]  = mk(1,'h20, 0,0,4'h0,0,0,         1,0,32'h0,        F_IG|F_MR, 0,0, 'h20,4'h0,0);
    tbl[8]  = mk(0,0,    0,0,4'h0,0,0,         0,1,32'h12345678, F_IV|F_BS, 32'h12345678,0, 0,0,0);
    for (int k = 9; k <= 13; k++)
      tbl[k] = mk(0,0,   1,1,4'h0,'h55,0,      0,0,32'h0,        F_MR,      0,0, 'h55,4'h0,0);
    tbl[14] = mk(0,0,    1,1,4'h0,'h55,0,      1,0,32'h0,        F_DG|F_MR, 0,0, 'h55,4'h0,0);
    tbl[15] = mk(0,0,    0,0,4'h0,0,0,         0,1,32'hCAFEF00D, F_DV|F_BS, 0,32'hCAFEF00D, 0,0,0);
    tbl[16] = mk(0,0,    0,0,4'h0,0,0,         0,0,32'h0,        8'h00,     0,0, 0,0,0);

    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      i_req = tbl[k].ir; i_addr = tbl[k].ia; d_req = tbl[k].dr; d_re = tbl[k].dre;
      d_we = tbl[k].dwe; d_addr = tbl[k].da; d_wdata = tbl[k].dwd;
      m_gnt = tbl[k].mg; m_rvalid = tbl[k].mv; m_rdata = tbl[k].mrd;
      #1;
      chk($sformatf("vec%0d_flags", k), {24'h0, flg}, {24'h0, tbl[k].fl});
      if (tbl[k].fl & F_MR) begin
        chk($sformatf("vec%0d_m_addr", k), {2'b0, m_addr}, {2'b0, tbl[k].ma});
        chk($sformatf("vec%0d_m_we", k), {28'h0, m_we}, {28'h0, tbl[k].mwe});
        chk($sformatf("vec%0d_m_wdata", k), m_wdata, tbl[k].mwd);
      end
      if (tbl[k].fl & F_IV) chk($sformatf("vec%0d_i_rdata", k), i_rdata, tbl[k].ird);
      if (tbl[k].fl & F_DV) chk($sformatf("vec%0d_d_rdata", k), d_rdata, tbl[k].drd);
    end

    // starvation guard: both requesting back to back
    order_exp = "DDDDIDDDDI";
    ng = 0;
    @(negedge clk);
    i_req = 1; i_addr = 'h100; d_req = 1; d_re = 1; d_addr = 'h200;
    m_gnt = 1; m_rvalid = 1; m_rdata = 0;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (i_gnt || d_gnt) begin
        chk($sformatf("starve_grant%0d", ng), {24'h0, (i_gnt ? 8'h49 : 8'h44)},
            {24'h0, order_exp[ng]});
        ng++;
      end
    end
    chk("starve_grant_count", ng, 10);
    @(negedge clk);
    i_req = 0; d_req = 0; d_re = 0; m_gnt = 0;
    #1;
    chk("starve_last_rsp", {24'h0, flg}, {24'h0, F_IV | F_BS});
    @(negedge clk);
    m_rvalid = 0;
    #1;
    chk("starve_idle", {24'h0, flg}, 32'h0);

    // timeout on a data read, then a late m_rvalid
    @(negedge clk);
    d_req = 1; d_re = 1; d_addr = 'h7; m_gnt = 1; m_rdata = 32'hFFFFFFFF;
    #1;
    chk("tmo_grant", {24'h0, flg}, {24'h0, F_DG | F_MR});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      d_req = 0; d_re = 0; m_gnt = 0;
      #1;
      if (k < 8) chk($sformatf("tmo_wait%0d", k), {24'h0, flg}, {24'h0, F_BS});
      else begin
        chk("tmo_err", {24'h0, flg}, {24'h0, F_DV | F_DE | F_BS});
        chk("tmo_rdata", d_rdata, 32'h0);
      end
    end
    @(negedge clk);
    m_rvalid = 1;
    #1;
    chk("tmo_late_ignored", {24'h0, flg}, 32'h0);
    @(negedge clk);
    m_rvalid = 0;
    #1;
    chk("tmo_late_idle", {24'h0, flg}, 32'h0);

    // m_rvalid on the timeout cycle wins
    @(negedge clk);
    d_req = 1; d_re = 1; m_gnt = 1;
    #1;
    chk("race_grant", {24'h0, flg}, {24'h0, F_DG | F_MR});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      d_req = 0; d_re = 0; m_gnt = 0;
      if (k == 8) begin m_rvalid = 1; m_rdata = 32'h0BADF00D; end
      #1;
      if (k < 8) chk($sformatf("race_wait%0d", k), {24'h0, flg}, {24'h0, F_BS});
      else begin
        chk("race_rsp", {24'h0, flg}, {24'h0, F_DV | F_BS});
        chk("race_rdata", d_rdata, 32'h0BADF00D);
      end
    end
    @(negedge clk);
    m_rvalid = 0;
    #1;
    chk("race_idle", {24'h0, flg}, 32'h0);

    // reset asserted in the middle of WAIT
    @(negedge clk);
    i_req = 1; i_addr = 'h33; m_gnt = 1;
    #1;
    chk("rst_grant", {24'h0, flg}, {24'h0, F_IG | F_MR});
    @(negedge clk);
    m_gnt = 0; d_req = 1; d_re = 1; d_we = 4'hF; d_wdata = 32'h11; d_addr = 'h44;
    m_rdata = 32'h5A5A5A5A;
    #1;
    chk("rst_busy", {24'h0, flg}, {24'h0, F_BS});
    rst_n = 0;
    #1;
    chk("rst_flags", {24'h0, flg}, 32'h0);
    chk("rst_m_outs", {m_addr, m_re, m_we != 0}, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    @(negedge clk);
    m_rvalid = 1;
    #1;
    chk("rst_hold", {24'h0, flg}, 32'h0);
    @(negedge clk);
    rst_n = 1; i_req = 0; d_req = 0; d_re = 0; d_we = 0;
    #1;
    chk("rst_old_rsp_dropped", {24'h0, flg}, 32'h0);
    @(negedge clk);
    m_rvalid = 0; i_req = 1; i_addr = 'h77; m_gnt = 1;
    #1;
    chk("rst_new_grant", {24'h0, flg}, {24'h0, F_IG | F_MR});
    chk("rst_new_addr", {2'b0, m_addr}, 32'h77);
    @(negedge clk);
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h600DCAFE;
    #1;
    chk("rst_new_rsp", {24'h0, flg}, {24'h0, F_IV | F_BS});
    chk("rst_new_rdata", i_rdata, 32'h600DCAFE);
    @(negedge clk);
    m_rvalid = 0;
    #1;
    chk("final_idle", {24'h0, flg}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
